xil_dip_sink: RTL and testbench

//  Consumer end of the DIP-sample handshake (rdy_for_data / data_rdy / data_in).

---
 rtl/xil_dip_pkg.sv | 7 +
 rtl/xil_dip_sink_if.sv | 9 +
 rtl/xil_sync_fifo.sv | 41 ++++
 rtl/xil_dip_sink.sv | 97 +++++++++
 tb/tb_xil_dip_sink.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/xil_dip_pkg.sv
// Shared types and default widths for the DIP-sample sink.
package xil_dip_pkg;
  typedef enum logic [1:0] {IDLE = 2'b01, HOLD = 2'b10} sink_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LED_W  = 8;
endpackage

// File: rtl/xil_dip_sink_if.sv
// DIP-sample handshake: source drives data_rdy/data_in, sink answers with rdy_for_data.
interface xil_dip_sink_if #(parameter int DATA_W = 32);
  logic              data_rdy;
  logic [DATA_W-1:0] data_in;
  logic              rdy_for_data;

  modport master (output data_rdy, data_in, input rdy_for_data);
  modport slave  (input data_rdy, data_in, output rdy_for_data);
endinterface

// File: rtl/xil_sync_fifo.sv
// First-word-fall-through FIFO; head is valid whenever empty is low.
module xil_sync_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/xil_dip_sink.sv
// DIP-sample consumer: drops repeated samples, queues changes, and shows each on the LEDs.
module xil_dip_sink
  import xil_dip_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LED_W       = DEF_LED_W,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  xil_dip_sink_if.slave    bus,
  output logic [LED_W-1:0] GPIO_LED,
  output logic             led_busy,
  output logic [15:0]      chg_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic              rdy_q, have_last, acc, push, pop;
  logic [DATA_W-1:0] last, head;
  logic              empty, full;
  logic [CW-1:0]     count, cnt_next;
  sink_state_t       state, state_n;
  logic [HW-1:0]     hcnt, hcnt_n;
  logic [LED_W-1:0]  led_n;
  wire               unused_fifo = ^{head, full};

  xil_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.data_in),
    .pop   (pop),
    .head  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign acc      = rdy_q & bus.data_rdy;
  assign push     = acc & (~have_last | (bus.data_in != last));
  assign cnt_next = count + CW'(push) - CW'(pop);

  // Ready looks at next-cycle occupancy, so a full FIFO can never see a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q     <= 1'b0;
      have_last <= 1'b0;
      last      <= '0;
      chg_cnt   <= '0;
    end else begin
      rdy_q <= (cnt_next < CW'(DEPTH));
      if (push) begin
        last      <= bus.data_in;
        have_last <= 1'b1;
        chg_cnt   <= chg_cnt + 16'd1;
      end
    end
  end

  assign bus.rdy_for_data = rdy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hcnt     <= '0;
      GPIO_LED <= '0;
    end else begin
      state    <= state_n;
      hcnt     <= hcnt_n;
      GPIO_LED <= led_n;
    end
  end

  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    led_n   = GPIO_LED;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        led_n   = head[LED_W-1:0];
        hcnt_n  = HW'(HOLD_CYCLES - 1);
        state_n = HOLD;
      end
      HOLD: begin
        if (hcnt == '0) state_n = IDLE;
        else            hcnt_n  = hcnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign led_busy = (state == HOLD);
endmodule

// File: tb/tb_xil_dip_sink.sv
// Directed vectors and hand sequences for xil_dip_sink (DEPTH=4, HOLD_CYCLES=16).
module tb_xil_dip_sink;
  import xil_dip_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  GPIO_LED;
  logic        led_busy;
  logic [15:0] chg_cnt;
  int          n_chk = 0;
  int          n_pass = 0;

  xil_dip_sink_if #(.DATA_W(32)) bus ();

  xil_dip_sink #(.DATA_W(32), .LED_W(8), .DEPTH(4), .HOLD_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .GPIO_LED (GPIO_LED),
    .led_busy (led_busy),
    .chg_cnt  (chg_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dr;
    logic [31:0] din;
    logic        exp_rdy;
    logic [7:0]  exp_led;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];
  int   log_cyc[$];
  int   log_val[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic cyc(input logic dr, input logic [31:0] din);
    bus.data_rdy = dr;
    bus.data_in  = din;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.data_rdy = 1'b0;
    bus.data_in  = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] prev;
    rst = 1'b1;
    bus.data_rdy = 1'b0;
    bus.data_in  = '0;

    // Reset state, then ready one edge after release
    @(negedge clk);
    @(negedge clk);
    chk("rst_led",  GPIO_LED, 0);
    chk("rst_busy", led_busy, 0);
    chk("rst_cnt",  chg_cnt, 0);
    chk("rst_rdy",  bus.rdy_for_data, 0);
    rst = 1'b0;
    #1 chk("rdy_before_edge", bus.rdy_for_data, 0);
    @(negedge clk);
    chk("rdy_after_edge", bus.rdy_for_data, 1);

    // Single change A5: one-cycle latency, 16 cycles of busy
    tbl.push_back('{1'b1, 32'hA5, 1'b1, 8'h00, 1'b0, 16'd1});
    for (int i = 0; i < 16; i++) tbl.push_back('{1'b0, 32'h0, 1'b1, 8'hA5, 1'b1, 16'd1});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 8'hA5, 1'b0, 16'd1});
    tbl.push_back('{1'b0, 32'h0, 1'b1, 8'hA5, 1'b0, 16'd1});
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].dr, tbl[i].din);
      chk($sformatf("v%0d_rdy", i),  bus.rdy_for_data, tbl[i].exp_rdy);
      chk($sformatf("v%0d_led", i),  GPIO_LED, tbl[i].exp_led);
      chk($sformatf("v%0d_busy", i), led_busy, tbl[i].exp_busy);
      chk($sformatf("v%0d_cnt", i),  chg_cnt, tbl[i].exp_cnt);
    end

    // Repeat filter: 3C held for 50 cycles is pushed once
    do_reset();
    for (int i = 0; i < 50; i++) begin
      cyc(1'b1, 32'h3C);
      if (i == 0) chk("rep_cnt0", chg_cnt, 1);
      if (i == 1) chk("rep_led1", GPIO_LED, 8'h3C);
      if (i == 1) chk("rep_busy1", led_busy, 1);
    end
    chk("rep_cnt",   chg_cnt, 1);
    chk("rep_led",   GPIO_LED, 8'h3C);
    chk("rep_busy",  led_busy, 0);
    chk("rep_rdy",   bus.rdy_for_data, 1);
    chk("rep_count", dut.u_fifo.count, 0);
    bus.data_rdy = 1'b0;

    // Backpressure: 01..06 offered back to back, 06 arrives while not ready
    do_reset();
    prev = 8'h00;
    for (int e = 1; e <= 76; e++) begin
      if (e <= 6) cyc(1'b1, 32'(e));
      else        cyc(1'b0, 32'h0);
      if (GPIO_LED !== prev) begin
        log_cyc.push_back(e);
        log_val.push_back(int'(GPIO_LED));
        prev = GPIO_LED;
      end
      if (e == 4)  chk("bp_rdy_e4",  bus.rdy_for_data, 1);
      if (e == 5)  chk("bp_rdy_e5",  bus.rdy_for_data, 0);
      if (e == 6)  chk("bp_rdy_e6",  bus.rdy_for_data, 0);
      if (e == 6)  chk("bp_cnt_e6",  chg_cnt, 5);
      if (e == 18) chk("bp_rdy_e18", bus.rdy_for_data, 0);
      if (e == 19) chk("bp_rdy_e19", bus.rdy_for_data, 1);
    end
    chk("bp_nupd", log_cyc.size(), 5);
    for (int k = 0; k < 5 && k < log_cyc.size(); k++) begin
      chk($sformatf("bp_upd%0d_val", k), log_val[k], k + 1);
      chk($sformatf("bp_upd%0d_cyc", k), log_cyc[k], 2 + 17 * k);
    end
    chk("bp_cnt_end", chg_cnt, 5);

    // Simultaneous push and pop at three entries
    do_reset();
    cyc(1'b1, 32'h11);
    cyc(1'b1, 32'h22);
    cyc(1'b1, 32'h33);
    cyc(1'b1, 32'h44);
    for (int e = 5; e <= 18; e++) cyc(1'b0, 32'h0);
    chk("pp_count_pre", dut.u_fifo.count, 3);
    chk("pp_busy_pre",  led_busy, 0);
    chk("pp_rdy_pre",   bus.rdy_for_data, 1);
    cyc(1'b1, 32'h55);
    chk("pp_count", dut.u_fifo.count, 3);
    chk("pp_rdy",   bus.rdy_for_data, 1);
    chk("pp_led",   GPIO_LED, 8'h22);
    chk("pp_cnt",   chg_cnt, 5);
    bus.data_rdy = 1'b0;

    // Mid-cycle reset while holding with two queued; 3C accepted again afterwards
    do_reset();
    cyc(1'b1, 32'h01);
    cyc(1'b1, 32'h02);
    cyc(1'b1, 32'h3C);
    bus.data_rdy = 1'b0;
    chk("mr_count_pre", dut.u_fifo.count, 2);
    chk("mr_busy_pre",  led_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_led",   GPIO_LED, 0);
    chk("mr_busy",  led_busy, 0);
    chk("mr_rdy",   bus.rdy_for_data, 0);
    chk("mr_cnt",   chg_cnt, 0);
    chk("mr_count", dut.u_fifo.count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mr_rdy_rel", bus.rdy_for_data, 0);
    @(negedge clk);
    chk("mr_rdy_edge", bus.rdy_for_data, 1);
    cyc(1'b1, 32'h3C);
    chk("mr_cnt_after", chg_cnt, 1);
    cyc(1'b0, 32'h0);
    chk("mr_led_after",  GPIO_LED, 8'h3C);
    chk("mr_busy_after", led_busy, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
